// File: rtl/ram_pkg.sv
// Shared types and constants for the parametrised scratch RAM.
package ram_pkg;

  localparam int RD_LAT_MAX = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic int num_lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Delay line for read data + valid; wires straight through when STAGES is 0.
module ram_rd_pipe #(
  parameter int STAGES = 0,
  parameter int W      = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (STAGES == 0) begin : g_pass
    assign q = d;
  end else begin : g_pipe
    logic [STAGES-1:0][W-1:0] pipe_q, pipe_d;

    always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = d;
      for (int i = 1; i < STAGES; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pipe_q <= '0;
      else          pipe_q <= pipe_d;
    end

    assign q = pipe_q[STAGES-1];
  end

endmodule

// File: rtl/ram_param.sv
// Single-port synchronous RAM with byte enables, 1/2-cycle read latency and a
// zero-fill sequencer that runs after reset and on clr.
module ram_param
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [DATA_W/8-1:0]   S_be,
  input  logic [ADDR_W-1:0]     S_addr,
  input  logic [DATA_W-1:0]     S_din,
  input  logic                  clr,
  output logic [DATA_W-1:0]     S_dout,
  output logic                  S_rvalid,
  output logic                  busy
);

  localparam int NUM_BE = num_lanes(DATA_W);
  localparam int DEPTH  = 1 << ADDR_W;

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX || (DATA_W % 8) != 0) begin : g_bad_param
    $error("ram_param: RD_LAT must be 1 or 2 and DATA_W a multiple of 8");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              clr_wr, usr_wr;

  assign clr_wr = (state_q == ST_CLEAR);
  assign usr_wr = (state_q == ST_IDLE) && cen && wen;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    rd_vld_d  = 1'b0;
    rd_data_d = '0;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        if (cen && !wen) begin
          rd_vld_d  = 1'b1;
          rd_data_d = mem[S_addr];
        end
        // An access sampled alongside clr is still serviced; clearing starts next cycle.
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      ptr_q     <= '0;
      busy_q    <= 1'b1;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is deliberately unreset; the clear sequencer provides defined contents.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[ptr_q] <= '0;
    end else if (usr_wr) begin
      for (int k = 0; k < NUM_BE; k++)
        if (S_be[k]) mem[S_addr][8*k +: 8] <= S_din[8*k +: 8];
    end
  end

  ram_rd_pipe #(
    .STAGES (RD_LAT - 1),
    .W      (DATA_W + 1)
  ) u_rd_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .d       ({rd_vld_q, rd_data_q}),
    .q       ({S_rvalid, S_dout})
  );

  assign busy = busy_q;

  a_be_known: assert property (@(posedge clk) disable iff (!reset_n)
    usr_wr |-> !$isunknown(S_be));

endmodule

// File: tb/tb_ram_param.sv
// Directed bench: one RAM with RD_LAT=1 and one with RD_LAT=2 share the stimulus.
module tb_ram_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cen, wen, clr;
  logic [3:0]  S_be;
  logic [4:0]  S_addr;
  logic [31:0] S_din;
  logic [31:0] dout1, dout2;
  logic        rv1, rv2, busy1, busy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_param #(.DATA_W(32), .ADDR_W(5), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cen(cen), .wen(wen), .S_be(S_be),
    .S_addr(S_addr), .S_din(S_din), .clr(clr),
    .S_dout(dout1), .S_rvalid(rv1), .busy(busy1));

  ram_param #(.DATA_W(32), .ADDR_W(5), .RD_LAT(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .cen(cen), .wen(wen), .S_be(S_be),
    .S_addr(S_addr), .S_din(S_din), .clr(clr),
    .S_dout(dout2), .S_rvalid(rv2), .busy(busy2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cen = 1'b0; wen = 1'b0; clr = 1'b0; S_be = 4'h0; S_addr = '0; S_din = '0;
  endtask

  task automatic do_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    cen = 1'b1; wen = 1'b1; S_addr = a; S_din = d; S_be = be;
    tick();
    idle_in();
  endtask

  // Counts cycles until busy drops, with whatever inputs the caller left driven.
  task automatic wait_busy(output int n, output bit saw_v);
    n = 0; saw_v = 1'b0;
    while (busy1 && n < 200) begin
      tick();
      n++;
      if (rv1 || rv2) saw_v = 1'b1;
    end
  endtask

  int n;
  bit saw_v;
  logic [31:0] e1 [5];
  logic [31:0] e2 [5];

  initial begin
    idle_in();
    reset_n = 1'b0;
    #23;
    chk("rst_busy", {busy1, busy2}, 2'b11);
    chk("rst_out1", {rv1, dout1}, 33'h0);
    chk("rst_out2", {rv2, dout2}, 33'h0);

    // Reset release: busy for exactly DEPTH cycles.
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_busy(n, saw_v);
    chk("init_busy_len", n, 32);
    chk("init_no_rvalid", saw_v, 1'b0);
    chk("busy2_low", busy2, 1'b0);

    // Every address reads back zero, one read per cycle.
    for (int a = 0; a < 32; a++) begin
      cen = 1'b1; wen = 1'b0; S_addr = 5'(a);
      tick();
      chk($sformatf("zero_rd%0d", a), {rv1, dout1}, {1'b1, 32'h0});
    end
    idle_in();
    tick();
    chk("zero_rd_tail2", {rv2, dout2}, {1'b1, 32'h0});
    tick();
    chk("idle_out1", {rv1, dout1}, 33'h0);
    chk("idle_out2", {rv2, dout2}, 33'h0);

    // Byte-enable merge plus a no-op write.
    do_wr(5'd3, 32'hDEADBEEF, 4'b1111);
    chk("wr_no_rvalid", {rv1, dout1}, 33'h0);
    do_wr(5'd3, 32'h11223344, 4'b0101);
    do_wr(5'd3, 32'hFFFFFFFF, 4'b0000);
    cen = 1'b1; wen = 1'b0; S_addr = 5'd3;
    tick();
    idle_in();
    chk("be_merge_l1", {rv1, dout1}, {1'b1, 32'hDE22BE44});
    chk("be_merge_l2_early", {rv2, dout2}, 33'h0);
    tick();
    chk("be_merge_l2", {rv2, dout2}, {1'b1, 32'hDE22BE44});
    chk("be_merge_l1_after", {rv1, dout1}, 33'h0);

    // Back-to-back reads: latency 1 vs latency 2.
    do_wr(5'd1, 32'hA, 4'hF);
    do_wr(5'd2, 32'hB, 4'hF);
    do_wr(5'd3, 32'hC, 4'hF);
    e1 = '{32'hA, 32'hB, 32'hC, 32'h0, 32'h0};
    e2 = '{32'h0, 32'hA, 32'hB, 32'hC, 32'h0};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin cen = 1'b1; wen = 1'b0; S_addr = 5'(i + 1); end
      else idle_in();
      tick();
      chk($sformatf("b2b_l1_c%0d", i), {rv1, dout1}, {(i < 3), e1[i]});
      chk($sformatf("b2b_l2_c%0d", i), {rv2, dout2}, {(i >= 1 && i < 4), e2[i]});
    end

    // clr with a read in flight; writes during the clear are dropped.
    do_wr(5'd7, 32'h5, 4'hF);
    cen = 1'b1; wen = 1'b0; S_addr = 5'd7; clr = 1'b1;
    tick();
    chk("clr_rd_l1", {rv1, dout1}, {1'b1, 32'h5});
    chk("clr_busy_rise", busy1, 1'b1);
    idle_in();
    cen = 1'b1; wen = 1'b1; S_addr = 5'd0; S_din = 32'hFFFFFFFF; S_be = 4'hF;
    tick();
    chk("clr_rd_l2", {rv2, dout2}, {1'b1, 32'h5});
    chk("clr_l1_quiet", rv1, 1'b0);
    wait_busy(n, saw_v);
    idle_in();
    chk("clr_busy_len", n + 1, 32);
    chk("clr_no_rvalid", saw_v, 1'b0);
    cen = 1'b1; wen = 1'b0; S_addr = 5'd7;
    tick();
    chk("clr_addr7", {rv1, dout1}, {1'b1, 32'h0});
    S_addr = 5'd0;
    tick();
    chk("drop_wr_addr0", {rv1, dout1}, {1'b1, 32'h0});
    idle_in();
    tick();

    // Reset during a pending latency-2 read discards it.
    do_wr(5'd5, 32'h1234, 4'hF);
    cen = 1'b1; wen = 1'b0; S_addr = 5'd5;
    tick();
    idle_in();
    chk("rd5_l1", {rv1, dout1}, {1'b1, 32'h1234});
    #2 reset_n = 1'b0;
    #1;
    chk("midrd_rst_l1", {rv1, dout1}, 33'h0);
    chk("midrd_rst_busy", busy1, 1'b1);
    tick();
    chk("midrd_flushed_l2", {rv2, dout2}, 33'h0);
    reset_n = 1'b1;
    wait_busy(n, saw_v);
    chk("midrd_busy_len", n, 32);

    // Reset at clear pointer 10 restarts a full clear; reads during busy are dropped.
    clr = 1'b1;
    tick();
    clr = 1'b0; cen = 1'b1; wen = 1'b0; S_addr = 5'd5;
    for (int i = 0; i < 10; i++) tick();
    chk("ptr10_busy", busy1, 1'b1);
    chk("ptr10_no_rvalid", {rv1, rv2}, 2'b00);
    #2 reset_n = 1'b0;
    #1;
    chk("ptr10_rst_out", {rv1, dout1, rv2, dout2}, 66'h0);
    tick();
    reset_n = 1'b1;
    wait_busy(n, saw_v);
    chk("ptr10_busy_len", n, 32);
    chk("ptr10_busy_no_rvalid", saw_v, 1'b0);
    tick();
    chk("post_rd5_l1", {rv1, dout1}, {1'b1, 32'h0});
    idle_in();
    tick();
    chk("post_rd5_l2", {rv2, dout2}, {1'b1, 32'h0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_param.md
Name: ram_param

Overview:
- Parametrised single-port synchronous RAM for the ALU/multiplier datapath; successor to the fixed 32x32 scratch RAM.
- Adds configurable width and depth, per-byte write enables, selectable read latency (1 or 2), a read-valid strobe, and a hardware clear sequencer.
- The clear sequencer zero-fills the array after reset and on request, so no simulation-only initialisation is needed.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width in bits; DEPTH = 2**ADDR_W words.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2 (any other value is an elaboration error).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cen  in  1  chip enable; access requested when 1.
- wen  in  1  write enable; with cen=1, 1 = write, 0 = read.
- S_be  in  DATA_W/8  byte write enables; bit k covers S_din[8k+7:8k].
- S_addr  in  ADDR_W  word address.
- S_din  in  DATA_W  write data.
- clr  in  1  single-cycle request to zero the whole array.
- S_dout  out  DATA_W  read data.
- S_rvalid  out  1  high for exactly one cycle when S_dout carries read data.
- busy  out  1  high while the clear sequencer owns the array.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - S_dout=0, S_rvalid=0, read pipeline flushed.
  - busy=1, state=CLEAR, clear pointer ptr=0.
  - Array contents are not reset directly; the clear sequence zeroes them.
- FSM states:
  - CLEAR: each cycle write 0 to mem[ptr] and increment ptr. At ptr=DEPTH-1, write the last word and go to IDLE. busy=1 throughout, so busy is high for exactly DEPTH cycles after reset release.
  - IDLE: busy=0; user accesses are serviced. clr=1 sends the FSM to CLEAR with ptr=0; busy rises the cycle after clr is sampled.
- clr while in CLEAR is ignored; it does not restart the pointer.
- User access while busy=1 is dropped: no write, no S_rvalid, no error indication.
- Write (IDLE, cen=1, wen=1):
  - On the clock edge, only the bytes with S_be[k]=1 are updated at mem[S_addr].
  - S_be=0 is a legal no-op write.
  - A write does not generate S_rvalid.
- Read (IDLE, cen=1, wen=0):
  - RD_LAT=1: S_dout=mem[S_addr] and S_rvalid=1 in the cycle after the request edge.
  - RD_LAT=2: data is registered once more and appears one cycle later.
  - One read can be issued every cycle; results return in issue order.
- S_dout is 0 on every cycle where S_rvalid=0, including after writes, idle cycles, dropped accesses and reset.
- Read-after-write: a read of an address issued in the cycle after a write to it returns the newly written bytes. There is no same-cycle read/write (single port).
- In-flight reads: if clr is sampled while a read is in the pipeline, the read still completes with S_rvalid and the data sampled at issue.
- Reset asserted mid-CLEAR or mid-read: aborts immediately and restarts CLEAR from ptr=0; pending reads are discarded.
- Address wraps naturally within ADDR_W bits. Any X on S_be during a write is a verification error (assertion).

Decomposition:
- Shared package ram_pkg:
  - FSM state encoding (ST_IDLE, ST_CLEAR).
  - Helper function for byte-lane count (DATA_W/8).
  - Constant RD_LAT_MAX=2.
- One natural sub-module: ram_rd_pipe, a parametrised delay line (depth RD_LAT-1, payload DATA_W+1) carrying data and the valid bit. It is a pass-through when RD_LAT=1.
- The storage array and clear FSM stay in the top module.

Test Plan:
- Reset release, DATA_W=32, ADDR_W=5 -> busy=1 for exactly 32 cycles then 0; a read of every address returns 0x0000_0000 with S_rvalid.
- Write 0xDEADBEEF to addr 3 with S_be=4'b1111, then write 0x11223344 to addr 3 with S_be=4'b0101, then read addr 3 -> S_dout=0xDE22BE44, S_rvalid one cycle after the read (RD_LAT=1).
- RD_LAT=2: back-to-back reads of addr 1 (0xA), 2 (0xB), 3 (0xC) -> S_rvalid high on cycles +2, +3, +4 with 0xA, 0xB, 0xC; S_dout=0 on all other cycles.
- Write 0x5 to addr 7, then pulse clr while a read of addr 7 is in flight -> the read returns 0x5; busy high for 32 cycles; a later read of addr 7 returns 0; a write issued during busy is dropped.
- Assert reset_n=0 at CLEAR ptr=10 -> outputs go to 0 immediately; after release busy lasts a full 32 cycles.
- Write during busy with cen=1, wen=1, addr 0, data 0xFFFF_FFFF -> after clear completes, a read of addr 0 returns 0; S_rvalid never pulses during busy.
